pipe_stage_buf: RTL and testbench



---
 rtl/genshin_pipe_pkg.sv | 38 +++
 rtl/pipe_stage_buf_sat_counter.sv | 47 ++++
 rtl/pipe_stage_buf.sv | 207 ++++++++++++++++++++
 tb/tb_pipe_stage_buf.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/genshin_pipe_pkg.sv
// -----------------------------------------------------------------------------
// genshin_pipe_pkg
//
// Shared definitions for the elastic pipeline-stage buffers placed between the
// CPU pipeline stages (EXE->MEM, MEM->WB).
//
//   pipe_state_t   : buffer fill state (EMPTY, ONE = main valid,
//                    TWO = main and skid valid)
//   PIPE_OCC_W     : width of the occupancy report (counts 0..2)
//   pipe_occupancy : maps a fill state to its entry count
//
// The per-stage payload structs (Load/Store/Exception) live in the stage
// modules. The buffer only ever sees them as an opaque packed vector.
// -----------------------------------------------------------------------------
package genshin_pipe_pkg;

  localparam int PIPE_OCC_W = 2;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } pipe_state_t;

  // Entry count held in a given fill state.
  function automatic logic [PIPE_OCC_W-1:0] pipe_occupancy(input pipe_state_t s);
    logic [PIPE_OCC_W-1:0] occ;
    occ = '0;
    case (s)
      EMPTY:   occ = PIPE_OCC_W'(0);
      ONE:     occ = PIPE_OCC_W'(1);
      TWO:     occ = PIPE_OCC_W'(2);
      default: occ = PIPE_OCC_W'(0);
    endcase
    return occ;
  endfunction

endpackage : genshin_pipe_pkg

// File: rtl/pipe_stage_buf_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
//
// Free-running saturating event counter. It is used for the stall counter of
// pipe_stage_buf and for the other stage-performance counters. It counts up
// by one on each cycle where inc is high and sticks at all-ones. Only rst
// clears it.
//
// Parameters:
//   W      counter width
// Ports:
//   clk    in   rising-edge clock
//   rst    in   asynchronous, active-high reset (count -> 0)
//   inc    in   count this cycle
//   count  out  current count, W bits
// -----------------------------------------------------------------------------
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // At all-ones further events are dropped, so the value never wraps to 0.
  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule : sat_counter

// File: rtl/pipe_stage_buf.sv
// -----------------------------------------------------------------------------
// pipe_stage_buf
//
// Elastic pipeline-stage register with a valid/ready handshake, a synchronous
// flush and a saturating stall-cycle counter. The payload is opaque. The
// instantiating stage packs its own struct into in_data and unpacks out_data.
//
// Build option (macro PIPE_SKID_EN):
//   defined   : two entries (main + skid). in_ready is a flop decoded from the
//               next fill state, so the ready path from downstream does not
//               reach upstream combinationally. One transfer per cycle is
//               still sustained.
//   undefined : single entry. in_ready = !out_valid | out_ready, which passes
//               combinationally through out_ready. There is no skid register
//               and occupancy never exceeds 1.
//
// Parameters:
//   DATA_W     payload width
//   CNT_W      stall counter width
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous, active-high reset
//   flush      in   synchronous flush, drops all held entries
//   in_valid   in   upstream payload valid
//   in_ready   out  stage accepts this cycle
//   in_data    in   upstream payload
//   out_valid  out  payload presented downstream
//   out_ready  in   downstream accepts this cycle
//   out_data   out  downstream payload (all zeros when empty)
//   occupancy  out  entries held (0, 1, 2)
//   stall_cnt  out  cycles with out_valid & !out_ready, saturating
// -----------------------------------------------------------------------------
module pipe_stage_buf
  import genshin_pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_data,
  output logic [PIPE_OCC_W-1:0] occupancy,
  output logic [CNT_W-1:0]      stall_cnt
);

  pipe_state_t       state_q;
  pipe_state_t       state_d;
  logic [DATA_W-1:0] main_q;
  logic [DATA_W-1:0] main_d;

  logic in_fire;
  logic out_fire;
  logic stall_inc;

  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_q;
  assign occupancy = pipe_occupancy(state_q);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

`ifdef PIPE_SKID_EN

  logic [DATA_W-1:0] skid_q;
  logic [DATA_W-1:0] skid_d;
  logic              in_ready_q;
  logic              in_ready_d;

  // in_ready comes straight from a flop. It is low only while both entries
  // are full, so it never depends on this cycle's out_ready.
  assign in_ready = in_ready_q;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;

    if (flush) begin
      // Flush wins over both handshakes. An entry arriving this cycle is
      // dropped, and the stage owner gates any out_fire seen this cycle.
      state_d = EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_d = ONE;
            main_d  = in_data;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_d = in_data;
          end else if (in_fire) begin
            // Downstream stalled this cycle. Park the new word in skid.
            state_d = TWO;
            skid_d  = in_data;
          end else if (out_fire) begin
            state_d = EMPTY;
            main_d  = '0;
          end
        end
        TWO: begin
          // Upstream is held off (in_ready low), so only a drain can occur.
          if (out_fire) begin
            state_d = ONE;
            main_d  = skid_q;
            skid_d  = '0;
          end
        end
        default: begin
          state_d = EMPTY;
          main_d  = '0;
          skid_d  = '0;
        end
      endcase
    end

    in_ready_d = (state_d != TWO);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

`else

  // Single-entry build. A full stage accepts only when its word leaves this
  // same cycle, so ready passes combinationally from downstream to upstream.
  assign in_ready = ~out_valid | out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;

    if (flush) begin
      state_d = EMPTY;
      main_d  = '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_d = ONE;
            main_d  = in_data;
          end
        end
        ONE: begin
          // in_fire can only be high here together with out_fire.
          if (out_fire) begin
            if (in_fire) begin
              main_d = in_data;
            end else begin
              state_d = EMPTY;
              main_d  = '0;
            end
          end
        end
        default: begin
          state_d = EMPTY;
          main_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
    end
  end

`endif

  // A stall is a held output that downstream refuses. Flush does not clear
  // the count.
  assign stall_inc = out_valid & ~out_ready;

  sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_inc),
    .count (stall_cnt)
  );

endmodule : pipe_stage_buf

// File: tb/tb_pipe_stage_buf.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_buf
//
// Table-driven bench for pipe_stage_buf with a data scoreboard. When
// PIPE_SKID_EN is defined it checks the two-entry behaviour. Otherwise it
// checks the single-entry behaviour. A second instance with CNT_W = 3 checks
// that the stall counter saturates.
// -----------------------------------------------------------------------------
module tb_pipe_stage_buf;

`ifdef PIPE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [1:0]  occupancy;
  logic [15:0] stall_cnt;

  logic        flush2;
  logic        in_valid2;
  logic        in_ready2;
  logic [31:0] in_data2;
  logic        out_valid2;
  logic        out_ready2;
  logic [31:0] out_data2;
  logic [1:0]  occupancy2;
  logic [2:0]  stall_cnt2;

  always #5 clk = ~clk;

  pipe_stage_buf #(.DATA_W(32), .CNT_W(16)) dut (
    .clk (clk), .rst (rst), .flush (flush),
    .in_valid (in_valid), .in_ready (in_ready), .in_data (in_data),
    .out_valid (out_valid), .out_ready (out_ready), .out_data (out_data),
    .occupancy (occupancy), .stall_cnt (stall_cnt)
  );

  pipe_stage_buf #(.DATA_W(32), .CNT_W(3)) dut_c3 (
    .clk (clk), .rst (rst), .flush (flush2),
    .in_valid (in_valid2), .in_ready (in_ready2), .in_data (in_data2),
    .out_valid (out_valid2), .out_ready (out_ready2), .out_data (out_data2),
    .occupancy (occupancy2), .stall_cnt (stall_cnt2)
  );

  typedef struct {
    logic        vld;
    logic [31:0] data;
    logic        ordy;
    logic        fl;
    logic        exp_ovld;
    logic [1:0]  exp_occ;
    logic [31:0] exp_odata;
    logic        exp_irdy;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  int          vec_no = 0;
  logic [31:0] sb[$];
  logic        model_valid = 1'b0;
  logic [15:0] exp_stall   = '0;
  logic [15:0] stall_base;
  vec_t        tbl[$];

  function automatic vec_t mk(logic vld, logic [31:0] data, logic ordy, logic fl,
                              logic ovld, logic [1:0] occ, logic [31:0] odata,
                              logic irdy);
    vec_t v;
    v.vld = vld; v.data = data; v.ordy = ordy; v.fl = fl;
    v.exp_ovld = ovld; v.exp_occ = occ; v.exp_odata = odata; v.exp_irdy = irdy;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_in_ready"},  64'(in_ready),  64'd1);
    chk({tag, "_occupancy"}, 64'(occupancy), 64'd0);
    chk({tag, "_out_data"},  64'(out_data),  64'd0);
    chk({tag, "_stall_cnt"}, 64'(stall_cnt), 64'd0);
  endtask

  // Drive one vector, track the handshakes on the scoreboard just before the
  // edge, then compare the state after the edge.
  task automatic run_vec(input vec_t v);
    in_valid  = v.vld;
    in_data   = v.data;
    out_ready = v.ordy;
    flush     = v.fl;
    @(negedge clk);
    if (v.fl) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 64'(out_data), 64'hDEAD_0000_0000);
        end else begin
          chk("sb_data", 64'(out_data), 64'(sb.pop_front()));
        end
      end
      if (in_valid && in_ready) sb.push_back(in_data);
    end
    if (model_valid && !v.ordy && exp_stall != '1) exp_stall = exp_stall + 16'd1;
    @(posedge clk);
    #1;
    chk("out_valid", 64'(out_valid), 64'(v.exp_ovld));
    chk("occupancy", 64'(occupancy), 64'(v.exp_occ));
    chk("out_data",  64'(out_data),  64'(v.exp_odata));
    chk("in_ready",  64'(in_ready),  64'(v.exp_irdy));
    chk("stall_cnt", 64'(stall_cnt), 64'(exp_stall));
    model_valid = v.exp_ovld;
    $display("vec %0d: in_v=%0b in_d=%0h out_r=%0b fl=%0b -> out_v=%0b out_d=%0h occ=%0d in_r=%0b stall=%0d",
             vec_no, v.vld, v.data, v.ordy, v.fl, out_valid, out_data, occupancy, in_ready, stall_cnt);
    vec_no++;
  endtask

  task automatic run_tbl();
    for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i]);
    tbl.delete();
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    flush2 = 1'b0; in_valid2 = 1'b0; in_data2 = '0; out_ready2 = 1'b0;
    #1;
    check_reset_vals("reset");
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // Stream 0x1..0x8 with out_ready high, then drain.
    for (int k = 1; k <= 8; k++) tbl.push_back(mk(1, 32'(k), 1, 0, 1, 2'd1, 32'(k), 1));
    tbl.push_back(mk(0, 0, 1, 0, 0, 2'd0, 0, 1));
    run_tbl();

    // Backpressure with three offered words.
    if (SKID) begin
      tbl.push_back(mk(1, 32'hA, 0, 0, 1, 2'd1, 32'hA, 1));
      tbl.push_back(mk(1, 32'hB, 0, 0, 1, 2'd2, 32'hA, 0));
      tbl.push_back(mk(1, 32'hC, 0, 0, 1, 2'd2, 32'hA, 0));
      tbl.push_back(mk(1, 32'hC, 1, 0, 1, 2'd1, 32'hB, 1));
      tbl.push_back(mk(1, 32'hC, 1, 0, 1, 2'd1, 32'hC, 1));
    end else begin
      tbl.push_back(mk(1, 32'hA, 0, 0, 1, 2'd1, 32'hA, 0));
      tbl.push_back(mk(1, 32'hB, 0, 0, 1, 2'd1, 32'hA, 0));
      tbl.push_back(mk(1, 32'hB, 0, 0, 1, 2'd1, 32'hA, 0));
      tbl.push_back(mk(1, 32'hB, 1, 0, 1, 2'd1, 32'hB, 1));
      tbl.push_back(mk(1, 32'hC, 1, 0, 1, 2'd1, 32'hC, 1));
    end
    tbl.push_back(mk(0, 0, 1, 0, 0, 2'd0, 0, 1));
    run_tbl();

    // Five stall cycles.
    tbl.push_back(mk(1, 32'h44, 1, 0, 1, 2'd1, 32'h44, 1));
    run_tbl();
    stall_base = stall_cnt;
    for (int k = 0; k < 5; k++) tbl.push_back(mk(0, 0, 0, 0, 1, 2'd1, 32'h44, SKID));
    run_tbl();
    chk("stall_plus5", 64'(stall_cnt), 64'(stall_base + 16'd5));
    tbl.push_back(mk(0, 0, 1, 0, 0, 2'd0, 0, 1));
    run_tbl();

    // Flush while full and with a word offered in the same cycle.
    tbl.push_back(mk(1, 32'h11, 0, 0, 1, 2'd1, 32'h11, SKID));
    tbl.push_back(mk(1, 32'h22, 0, 0, 1, SKID ? 2'd2 : 2'd1, 32'h11, 0));
    tbl.push_back(mk(1, 32'h33, 1, 1, 0, 2'd0, 0, 1));
    tbl.push_back(mk(0, 0, 1, 0, 0, 2'd0, 0, 1));
    run_tbl();

    // Ready path with one entry held.
    tbl.push_back(mk(1, 32'h88, 0, 0, 1, 2'd1, 32'h88, SKID));
    run_tbl();
    in_valid = 1'b0; out_ready = 1'b0;
    #1 chk("irdy_ordy0", 64'(in_ready), 64'(SKID));
    out_ready = 1'b1;
    #1 chk("irdy_ordy1", 64'(in_ready), 64'd1);
    tbl.push_back(mk(0, 0, 1, 0, 0, 2'd0, 0, 1));
    run_tbl();

    // Asynchronous reset between clock edges while full.
    tbl.push_back(mk(1, 32'h55, 0, 0, 1, 2'd1, 32'h55, SKID));
    tbl.push_back(mk(1, 32'h66, 0, 0, 1, SKID ? 2'd2 : 2'd1, 32'h55, 0));
    run_tbl();
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1 check_reset_vals("async_rst");
    @(posedge clk); #3;
    rst = 1'b0;
    sb.delete(); model_valid = 1'b0; exp_stall = '0;
    #1 chk("post_rst_out_valid", 64'(out_valid), 64'd0);
    tbl.push_back(mk(1, 32'h77, 1, 0, 1, 2'd1, 32'h77, 1));
    tbl.push_back(mk(0, 0, 1, 0, 0, 2'd0, 0, 1));
    run_tbl();

    // Saturation on the 3-bit counter after 10 stall cycles.
    in_valid2 = 1'b1; in_data2 = 32'h99; out_ready2 = 1'b0;
    @(posedge clk); #1;
    in_valid2 = 1'b0;
    chk("c3_out_valid", 64'(out_valid2), 64'd1);
    chk("c3_out_data",  64'(out_data2),  64'h99);
    repeat (3) @(posedge clk);
    #1 chk("c3_stall3", 64'(stall_cnt2), 64'd3);
    repeat (7) @(posedge clk);
    #1 chk("c3_stall_sat", 64'(stall_cnt2), 64'd7);
    $display("c3: out_v=%0b stall=%0d", out_valid2, stall_cnt2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_pipe_stage_buf
